// File: rtl/alu_arbiter.sv
// Round-robin share of one combinational ALU between two issue ports; result returned per port with its tag.
// Latency: accept edge -> EXEC for one cycle -> rspN_valid after the following edge; one op in flight at a time.
// Backpressure: a response is held until its owner takes it, and no new request is granted until then.
module alu_arbiter #(
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [2:0]       req0_op,
    input  logic             req0_form,
    input  logic [1:0]       req0_vec,
    input  logic [31:0]      req0_a,
    input  logic [31:0]      req0_b,
    input  logic [31:0]      req0_c,
    input  logic [31:0]      req0_d,
    input  logic [TAG_W-1:0] req0_tag,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [2:0]       req1_op,
    input  logic             req1_form,
    input  logic [1:0]       req1_vec,
    input  logic [31:0]      req1_a,
    input  logic [31:0]      req1_b,
    input  logic [31:0]      req1_c,
    input  logic [31:0]      req1_d,
    input  logic [TAG_W-1:0] req1_tag,

    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic [31:0]      rsp0_y1,
    output logic [31:0]      rsp0_y2,
    output logic [TAG_W-1:0] rsp0_tag,
    output logic             rsp0_err,

    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [31:0]      rsp1_y1,
    output logic [31:0]      rsp1_y2,
    output logic [TAG_W-1:0] rsp1_tag,
    output logic             rsp1_err,

    output logic [2:0]       alu_op,
    output logic             alu_form,
    output logic [1:0]       alu_vec,
    output logic [31:0]      alu_a,
    output logic [31:0]      alu_b,
    output logic [31:0]      alu_c,
    output logic [31:0]      alu_d,
    input  logic [31:0]      alu_y1,
    input  logic [31:0]      alu_y2
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef struct packed {
        logic [2:0]       op;
        logic             form;
        logic [1:0]       vec;
        logic [31:0]      a;
        logic [31:0]      b;
        logic [31:0]      c;
        logic [31:0]      d;
        logic [TAG_W-1:0] tag;
    } issue_t;

    typedef struct packed {
        logic [31:0]      y1;
        logic [31:0]      y2;
        logic [TAG_W-1:0] tag;
        logic             err;
    } rsp_t;

    state_t     state;
    state_t     state_nxt;
    issue_t     iss_q;
    issue_t     req_sel;
    logic       owner_q;
    logic       last_grant_q;
    logic       grant_vld;
    logic       grant_port;
    logic       accept;
    logic       rsp_done;
    logic       op_ok;
    logic [1:0] rsp_rdy;
    logic [1:0] rsp_vld_q;
    rsp_t       rsp_q [2];

    // On a tie the port that did not win last time gets the grant.
    always_comb begin
        grant_vld  = req0_valid | req1_valid;
        grant_port = 1'b0;
        if (req0_valid && req1_valid) begin
            grant_port = ~last_grant_q;
        end else if (req1_valid) begin
            grant_port = 1'b1;
        end
    end

    assign accept     = (state == IDLE) && grant_vld;
    assign req0_ready = accept && !grant_port;
    assign req1_ready = accept && grant_port;

    always_comb begin
        req_sel = grant_port
                ? {req1_op, req1_form, req1_vec, req1_a, req1_b, req1_c, req1_d, req1_tag}
                : {req0_op, req0_form, req0_vec, req0_a, req0_b, req0_c, req0_d, req0_tag};
    end

    assign rsp_rdy  = {rsp1_ready, rsp0_ready};
    assign rsp_done = (state == RESP) && rsp_rdy[owner_q];
    assign op_ok    = (iss_q.op == 3'b000) || (iss_q.op == 3'b100);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant_vld) state_nxt = EXEC;
            EXEC:    state_nxt = RESP;
            RESP:    if (rsp_rdy[owner_q]) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            iss_q        <= '0;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
        end else begin
            state <= state_nxt;
            if (accept) begin
                iss_q        <= req_sel;
                owner_q      <= grant_port;
                last_grant_q <= grant_port;
            end
        end
    end

    // Response regs are cleared on hand-off so an idle port always presents zeros.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_vld_q <= 2'b00;
            rsp_q[0]  <= '0;
            rsp_q[1]  <= '0;
        end else if (state == EXEC) begin
            rsp_vld_q[owner_q] <= 1'b1;
            if (op_ok) begin
                rsp_q[owner_q] <= '{y1: alu_y1, y2: alu_y2, tag: iss_q.tag, err: 1'b0};
            end else begin
                rsp_q[owner_q] <= '{y1: '0, y2: '0, tag: iss_q.tag, err: 1'b1};
            end
        end else if (rsp_done) begin
            rsp_vld_q[owner_q] <= 1'b0;
            rsp_q[owner_q]     <= '0;
        end
    end

    assign alu_op   = iss_q.op;
    assign alu_form = iss_q.form;
    assign alu_vec  = iss_q.vec;
    assign alu_a    = iss_q.a;
    assign alu_b    = iss_q.b;
    assign alu_c    = iss_q.c;
    assign alu_d    = iss_q.d;

    assign rsp0_valid = rsp_vld_q[0];
    assign rsp0_y1    = rsp_q[0].y1;
    assign rsp0_y2    = rsp_q[0].y2;
    assign rsp0_tag   = rsp_q[0].tag;
    assign rsp0_err   = rsp_q[0].err;

    assign rsp1_valid = rsp_vld_q[1];
    assign rsp1_y1    = rsp_q[1].y1;
    assign rsp1_y2    = rsp_q[1].y2;
    assign rsp1_tag   = rsp_q[1].tag;
    assign rsp1_err   = rsp_q[1].err;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: stand-in ALU, request-level reference model and a response scoreboard.
module tb_alu_arbiter;
    localparam int TAG_W = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]       req_valid, req_ready, req_form;
    logic [2:0]       req_op  [2];
    logic [1:0]       req_vec [2];
    logic [31:0]      req_a [2], req_b [2], req_c [2], req_d [2];
    logic [TAG_W-1:0] req_tag [2];
    logic [1:0]       rsp_valid, rsp_ready, rsp_err;
    logic [31:0]      rsp_y1 [2], rsp_y2 [2];
    logic [TAG_W-1:0] rsp_tag [2];
    logic [2:0]       alu_op;
    logic             alu_form;
    logic [1:0]       alu_vec;
    logic [31:0]      alu_a, alu_b, alu_c, alu_d, alu_y1, alu_y2;

    alu_arbiter #(.TAG_W(TAG_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req_valid[0]), .req0_ready(req_ready[0]), .req0_op(req_op[0]), .req0_form(req_form[0]),
        .req0_vec(req_vec[0]), .req0_a(req_a[0]), .req0_b(req_b[0]), .req0_c(req_c[0]), .req0_d(req_d[0]),
        .req0_tag(req_tag[0]),
        .req1_valid(req_valid[1]), .req1_ready(req_ready[1]), .req1_op(req_op[1]), .req1_form(req_form[1]),
        .req1_vec(req_vec[1]), .req1_a(req_a[1]), .req1_b(req_b[1]), .req1_c(req_c[1]), .req1_d(req_d[1]),
        .req1_tag(req_tag[1]),
        .rsp0_valid(rsp_valid[0]), .rsp0_ready(rsp_ready[0]), .rsp0_y1(rsp_y1[0]), .rsp0_y2(rsp_y2[0]),
        .rsp0_tag(rsp_tag[0]), .rsp0_err(rsp_err[0]),
        .rsp1_valid(rsp_valid[1]), .rsp1_ready(rsp_ready[1]), .rsp1_y1(rsp_y1[1]), .rsp1_y2(rsp_y2[1]),
        .rsp1_tag(rsp_tag[1]), .rsp1_err(rsp_err[1]),
        .alu_op(alu_op), .alu_form(alu_form), .alu_vec(alu_vec),
        .alu_a(alu_a), .alu_b(alu_b), .alu_c(alu_c), .alu_d(alu_d),
        .alu_y1(alu_y1), .alu_y2(alu_y2)
    );

    // Stand-in ALU: lane-wise add/sub on (a,c) and (b,d); DOUBLE treats {a,b} and {c,d} as 64-bit; form swaps outputs.
    function automatic logic [63:0] alu_fn(input logic [2:0] op, input logic form, input logic [1:0] vec,
                                           input logic [31:0] a, input logic [31:0] b,
                                           input logic [31:0] c, input logic [31:0] d);
        logic [63:0] w;
        logic [31:0] y1, y2, m, x1, x2;
        int lw;
        y1 = '0;
        y2 = '0;
        if (vec == 2'd3) begin
            w  = op[2] ? ({a, b} - {c, d}) : ({a, b} + {c, d});
            y1 = w[63:32];
            y2 = w[31:0];
        end else begin
            lw = 8 << vec;
            m  = (lw == 32) ? 32'hFFFF_FFFF : ((32'd1 << lw) - 32'd1);
            for (int i = 0; i < 32; i += lw) begin
                x1 = op[2] ? ((a >> i) - (c >> i)) : ((a >> i) + (c >> i));
                x2 = op[2] ? ((b >> i) - (d >> i)) : ((b >> i) + (d >> i));
                y1 |= (x1 & m) << i;
                y2 |= (x2 & m) << i;
            end
        end
        return form ? {y2, y1} : {y1, y2};
    endfunction

    assign {alu_y1, alu_y2} = alu_fn(alu_op, alu_form, alu_vec, alu_a, alu_b, alu_c, alu_d);

    typedef struct {
        int               port;
        logic [31:0]      y1;
        logic [31:0]      y2;
        logic [31:0]      a;
        logic [2:0]       op;
        logic [TAG_W-1:0] tag;
        logic             err;
        int               acc;
    } exp_t;

    int   checks = 0;
    int   errors = 0;
    exp_t q [$];
    int   acc_log [$];
    int   acc_t [$];
    int   ncyc = 0;
    int   busy = 0;
    int   last = 1;
    int   wdog = 0;
    logic [1:0] prev_v = 2'b00;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s", name);
    endtask

    // Reference model + scoreboard: one op in flight, tie goes to the port that did not win last.
    always @(negedge clk) begin : monitor
        logic [1:0]  er;
        logic [63:0] r;
        exp_t        e;
        int          w;
        if (!rst_n) begin
            q.delete();
            busy   = 0;
            last   = 1;
            wdog   = 0;
            prev_v = 2'b00;
        end else begin
            er = 2'b00;
            w  = -1;
            if (busy == 0) begin
                if (req_valid == 2'b11)  w = 1 - last;
                else if (req_valid[0])   w = 0;
                else if (req_valid[1])   w = 1;
                if (w >= 0) er[w] = 1'b1;
            end
            chk("req_ready", 64'(req_ready), 64'(er));
            for (int p = 0; p < 2; p++) begin
                if (req_valid[p] && req_ready[p]) begin
                    r     = alu_fn(req_op[p], req_form[p], req_vec[p], req_a[p], req_b[p], req_c[p], req_d[p]);
                    e.port = p;
                    e.err  = !(req_op[p] == 3'b000 || req_op[p] == 3'b100);
                    e.y1   = e.err ? 32'd0 : r[63:32];
                    e.y2   = e.err ? 32'd0 : r[31:0];
                    e.a    = req_a[p];
                    e.op   = req_op[p];
                    e.tag  = req_tag[p];
                    e.acc  = ncyc;
                    q.push_back(e);
                    busy = 1;
                    last = p;
                    wdog = 0;
                    acc_log.push_back(p);
                    acc_t.push_back(ncyc);
                end
            end
            for (int p = 0; p < 2; p++) begin
                if (rsp_valid[p]) begin
                    if (q.size() == 0) begin
                        fail_now("rsp_unexpected");
                    end else begin
                        e = q[0];
                        chk("rsp_port", 64'(p), 64'(e.port));
                        chk("rsp_other_valid", 64'(rsp_valid[1-p]), 64'd0);
                        chk("rsp_y1", 64'(rsp_y1[p]), 64'(e.y1));
                        chk("rsp_y2", 64'(rsp_y2[p]), 64'(e.y2));
                        chk("rsp_tag", 64'(rsp_tag[p]), 64'(e.tag));
                        chk("rsp_err", 64'(rsp_err[p]), 64'(e.err));
                        chk("alu_a_held", 64'(alu_a), 64'(e.a));
                        chk("alu_op_held", 64'(alu_op), 64'(e.op));
                        if (!prev_v[p]) chk("latency", 64'(ncyc - e.acc), 64'd2);
                        if (rsp_ready[p]) begin
                            void'(q.pop_front());
                            busy = 0;
                        end
                    end
                end
            end
            if (busy != 0) begin
                wdog++;
                if (wdog > 30) begin
                    fail_now("rsp_timeout");
                    q.delete();
                    busy = 0;
                    wdog = 0;
                end
            end
            prev_v = rsp_valid;
        end
        ncyc++;
    end

    task automatic rand_fields(input int p);
        if ($urandom_range(0, 3) == 0) req_op[p] = 3'($urandom_range(0, 7));
        else                           req_op[p] = $urandom_range(0, 1) ? 3'b100 : 3'b000;
        req_form[p] = 1'($urandom_range(0, 1));
        req_vec[p]  = 2'($urandom_range(0, 3));
        req_a[p]    = $urandom;
        req_b[p]    = $urandom;
        req_c[p]    = $urandom;
        req_d[p]    = $urandom;
        req_tag[p]  = TAG_W'($urandom);
    endtask

    task automatic issue(input int p, input logic [2:0] op, input logic form, input logic [1:0] vec,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                         input logic [31:0] d, input logic [TAG_W-1:0] tag);
        int g;
        logic got;
        g   = 0;
        got = 1'b0;
        req_op[p] = op; req_form[p] = form; req_vec[p] = vec;
        req_a[p] = a; req_b[p] = b; req_c[p] = c; req_d[p] = d; req_tag[p] = tag;
        req_valid[p] = 1'b1;
        while (!got && g < 50) begin
            @(negedge clk);
            got = req_ready[p];
            g++;
            @(posedge clk);
            #1;
        end
        req_valid[p] = 1'b0;
        if (!got) fail_now("issue_timeout");
    endtask

    initial begin
        req_valid = 2'b00;
        rsp_ready = 2'b00;
        req_form  = 2'b00;
        for (int p = 0; p < 2; p++) begin
            req_op[p] = '0; req_vec[p] = '0; req_tag[p] = '0;
            req_a[p] = '0; req_b[p] = '0; req_c[p] = '0; req_d[p] = '0;
        end
        repeat (2) @(posedge clk);
        #1;
        chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("reset_alu_a", 64'(alu_a), 64'd0);
        chk("reset_alu_op", 64'(alu_op), 64'd0);
        chk("reset_rsp0_y1", 64'(rsp_y1[0]), 64'd0);
        rst_n = 1'b1;

        // Basic ADD FULL, then an operand change after acceptance.
        rsp_ready = 2'b11;
        issue(0, 3'b000, 1'b0, 2'd2, 32'd5, 32'd1, 32'd7, 32'd2, 4'd3);
        req_a[0] = 32'd9;
        repeat (4) @(posedge clk);
        #1;

        // Both ports valid continuously: strict alternation, 3-cycle accept spacing.
        acc_log.delete();
        acc_t.delete();
        for (int i = 0; i < 12; i++) begin
            rand_fields(0);
            rand_fields(1);
            req_tag[0] = TAG_W'(i);
            req_tag[1] = TAG_W'(i + 8);
            req_valid  = 2'b11;
            @(posedge clk);
            #1;
        end
        req_valid = 2'b00;
        repeat (4) @(posedge clk);
        #1;
        chk("alt_count_ge3", 64'(acc_log.size() >= 3), 64'd1);
        for (int i = 1; i < acc_log.size(); i++) begin
            chk("alt_port", 64'(acc_log[i]), 64'(1 - acc_log[i-1]));
            chk("accept_spacing", 64'(acc_t[i] - acc_t[i-1]), 64'd3);
        end

        // SUB DOUBLE held by port 1 while port 0 waits.
        rsp_ready = 2'b00;
        issue(1, 3'b100, 1'b0, 2'd3, 32'd0, 32'd0, 32'd0, 32'd1, 4'd9);
        rand_fields(0);
        req_valid[0] = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        rsp_ready = 2'b11;
        issue(0, 3'b000, 1'b1, 2'd0, 32'h1234_5678, 32'hFF00_FF00, 32'h0101_0101, 32'h0100_0100, 4'd5);
        repeat (4) @(posedge clk);
        #1;

        // Unsupported op.
        issue(0, 3'b010, 1'b0, 2'd2, 32'd11, 32'd22, 32'd33, 32'd44, 4'd7);
        repeat (4) @(posedge clk);
        #1;

        // Reset during EXEC, then a tie must go to port 0.
        issue(0, 3'b000, 1'b0, 2'd2, 32'd5, 32'd6, 32'd7, 32'd8, 4'd1);
        rst_n = 1'b0;
        #1;
        chk("midreset_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("midreset_alu_a", 64'(alu_a), 64'd0);
        @(negedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        rand_fields(0);
        rand_fields(1);
        req_valid = 2'b11;
        @(negedge clk);
        chk("post_reset_tie", 64'(req_ready), 64'd1);
        @(posedge clk);
        #1;
        req_valid = 2'b00;
        repeat (4) @(posedge clk);
        #1;

        // Randomized traffic with random response backpressure.
        for (int i = 0; i < 500; i++) begin
            for (int p = 0; p < 2; p++) begin
                rand_fields(p);
                req_valid[p] = ($urandom_range(0, 3) != 0);
                rsp_ready[p] = ($urandom_range(0, 2) != 0);
            end
            @(posedge clk);
            #1;
        end
        req_valid = 2'b00;
        rsp_ready = 2'b11;
        repeat (8) @(posedge clk);
        #1;
        chk("drain_empty", 64'(q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #300000;
        fail_now("global_timeout");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
